fir_decimator: RTL

Decimation stage directly downstream of the FIR filter. It takes the filtered sample stream (one sample per accepted cycle), keeps one sample per group of R input samples, and buffers the results in a small FIFO. The FIFO presents them to the capture/display path over a valid/ready handshake. Overflow is reported so acquisition logic can detect dropped groups.

---
 rtl/fir_decimator.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fir_decimator.sv
// Keeps the first sample of every R-sample group and queues it in a small output FIFO.
// Define FIR_DECIMATOR_PEAK_DETECT_EN to also queue each group's signed max and min.
module fir_decimator #(
  parameter int DATA_WIDTH  = 16,
  parameter int RATIO_WIDTH = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic [RATIO_WIDTH-1:0]       ratio,
  input  logic                         clear_ovf,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic [$clog2(FIFO_DEPTH):0]  fill,
`ifdef FIR_DECIMATOR_PEAK_DETECT_EN
  output logic signed [DATA_WIDTH-1:0] out_max,
  output logic signed [DATA_WIDTH-1:0] out_min,
`endif
  output logic                         overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
`ifdef FIR_DECIMATOR_PEAK_DETECT_EN
  localparam int FW = 3 * DATA_WIDTH;
`else
  localparam int FW = DATA_WIDTH;
`endif

  logic [RATIO_WIDTH-1:0]       phase;
  logic [RATIO_WIDTH-1:0]       ratio_q;
  logic [RATIO_WIDTH-1:0]       eff_r;
  logic [RATIO_WIDTH-1:0]       cur_r;
  logic signed [DATA_WIDTH-1:0] grp_data;
  logic signed [DATA_WIDTH-1:0] head;
  logic                         start;
  logic                         last;
  logic                         pop;
  logic                         full;
  logic                         push;
  logic                         drop;
  logic [FW-1:0]                entry;
  logic [FW-1:0]                head_e;
  logic [FW-1:0]                mem [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr;
  logic [AW-1:0]                rd_ptr;

  assign eff_r = (ratio < RATIO_WIDTH'(2)) ? RATIO_WIDTH'(1) : ratio;
  assign start = (phase == '0);
  // At a group start the incoming ratio governs, not the stale ratio_q
  assign cur_r = start ? eff_r : ratio_q;
  assign last  = in_valid && (phase == cur_r - RATIO_WIDTH'(1));
  assign head  = start ? in_data : grp_data;

  assign pop  = out_valid && out_ready;
  assign full = (fill == FULL);
  assign push = last && (!full || pop);
  assign drop = last && full && !pop;

`ifdef FIR_DECIMATOR_PEAK_DETECT_EN
  logic signed [DATA_WIDTH-1:0] grp_max;
  logic signed [DATA_WIDTH-1:0] grp_min;
  logic signed [DATA_WIDTH-1:0] max_n;
  logic signed [DATA_WIDTH-1:0] min_n;

  assign max_n = (start || in_data > grp_max) ? in_data : grp_max;
  assign min_n = (start || in_data < grp_min) ? in_data : grp_min;
  assign entry = {max_n, min_n, head};

  always_ff @(posedge clk) begin
    if (rst) begin
      grp_max <= '0;
      grp_min <= '0;
    end else if (in_valid) begin
      grp_max <= max_n;
      grp_min <= min_n;
    end
  end
`else
  assign entry = head;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= '0;
      ratio_q  <= RATIO_WIDTH'(1);
      grp_data <= '0;
    end else if (in_valid) begin
      if (start) begin
        ratio_q  <= eff_r;
        grp_data <= in_data;
      end
      phase <= last ? '0 : phase + RATIO_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fill <= fill + 1'b1;
      else if (pop && !push) fill <= fill - 1'b1;
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  assign out_valid = (fill != '0);
  assign head_e    = mem[rd_ptr];
  assign out_data  = out_valid ? head_e[DATA_WIDTH-1:0] : '0;
`ifdef FIR_DECIMATOR_PEAK_DETECT_EN
  assign out_min = out_valid ? head_e[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign out_max = out_valid ? head_e[3*DATA_WIDTH-1:2*DATA_WIDTH] : '0;
`endif

endmodule
